// File: rtl/clock_share_pkg.sv
// Shared types, default sizing and round-robin selection for clock_share_arbiter.
package clock_share_pkg;

  localparam int CS_NREQ  = 4;
  localparam int CS_WIDTH = 16;
  localparam int CS_BURST = 8;
  localparam int RR_MAX   = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } cs_state_e;

  typedef struct packed {
    logic       found;
    logic [4:0] idx;
  } rr_pick_t;

  // First requester strictly after 'last', wrapping; 'last' itself is checked last.
  function automatic rr_pick_t rr_select(input logic [RR_MAX-1:0] req,
                                         input logic [4:0]        last,
                                         input logic [5:0]        n);
    rr_pick_t   res;
    logic [5:0] idx;
    res.found = 1'b0;
    res.idx   = 5'd0;
    for (int i = 1; i <= RR_MAX; i++) begin
      idx = {1'b0, last} + 6'(i);
      if (idx >= n) begin
        idx = idx - n;
      end else begin
        idx = idx;
      end
      if (!res.found && (6'(i) <= n) && req[idx[4:0]]) begin
        res.found = 1'b1;
        res.idx   = idx[4:0];
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/even_period_divider.sv
// Even-period square-wave generator: N/2 cycles high then N/2 low, with a
// flag registered for the last low cycle of every period.
module even_period_divider
  import clock_share_pkg::*;
#(
  parameter int WIDTH = CS_WIDTH
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] half,
  output logic             out,
  output logic             period_end
);

  logic [WIDTH-1:0] cnt_r, cnt_s, last_s;
  logic             out_r, out_s;
  logic             started_r, started_s;
  logic             end_r, end_s;

  // Next phase position; the first enabled cycle after a clear starts high.
  always_comb begin
    last_s    = half - {{(WIDTH-1){1'b0}}, 1'b1};
    cnt_s     = {WIDTH{1'b0}};
    out_s     = 1'b0;
    started_s = 1'b0;
    end_s     = 1'b0;
    if (load || !enable) begin
      cnt_s     = {WIDTH{1'b0}};
      out_s     = 1'b0;
      started_s = 1'b0;
    end else if (!started_r) begin
      out_s     = 1'b1;
      started_s = 1'b1;
    end else begin
      started_s = 1'b1;
      if (cnt_r == last_s) begin
        cnt_s = {WIDTH{1'b0}};
        out_s = ~out_r;
      end else begin
        cnt_s = cnt_r + {{(WIDTH-1){1'b0}}, 1'b1};
        out_s = out_r;
      end
      end_s = !out_s && (cnt_s == last_s);
    end
  end

  // Phase registers; reset drops the output immediately.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cnt_r     <= {WIDTH{1'b0}};
      out_r     <= 1'b0;
      started_r <= 1'b0;
      end_r     <= 1'b0;
    end else begin
      cnt_r     <= cnt_s;
      out_r     <= out_s;
      started_r <= started_s;
      end_r     <= end_s;
    end
  end

  assign out        = out_r;
  assign period_end = end_r;

endmodule

// File: rtl/clock_share_arbiter.sv
// Round-robin owner of a shared divided clock, released after BURST periods.
// Define CLKSHARE_ERR_CHECK_EN to reject odd or sub-2 periods with an Err pulse.
module clock_share_arbiter
  import clock_share_pkg::*;
#(
  parameter int NREQ  = CS_NREQ,
  parameter int WIDTH = CS_WIDTH,
  parameter int BURST = CS_BURST
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [NREQ-1:0]       Req,
  input  logic [NREQ*WIDTH-1:0] DivN,
  output logic [NREQ-1:0]       Grant,
  output logic                  OUT,
  output logic                  Busy,
  output logic                  Period_done,
  output logic                  Err
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  cs_state_e         state_r, state_s;
  logic [IDXW-1:0]   owner_r, last_owner_r, win_s, owner_next_s;
  logic [WIDTH-1:0]  n_latched_r, period_cnt_r, cnt_inc_s, win_n_s, cand_n_s, half_s;
  logic [NREQ-1:0]   grant_r, grant_s;
  logic              busy_r, busy_s, err_r, err_s;
  logic [RR_MAX-1:0] req_ext_s;
  rr_pick_t          rr_s;
  logic              found_s, illegal_s, release_s, arb_s, take_s;
  logic              out_s, period_end_s;

  // Winner search, its period check and the period-end release decision.
  always_comb begin
    req_ext_s            = {RR_MAX{1'b0}};
    req_ext_s[NREQ-1:0]  = Req;
    rr_s                 = rr_select(req_ext_s, 5'(last_owner_r), 6'(NREQ));
    found_s              = rr_s.found && (rr_s.idx < 5'(NREQ));
    win_s                = rr_s.idx[IDXW-1:0];
    win_n_s              = DivN[int'(win_s)*WIDTH +: WIDTH];
`ifdef CLKSHARE_ERR_CHECK_EN
    illegal_s = win_n_s[0] || (win_n_s < WIDTH'(2));
    cand_n_s  = win_n_s;
`else
    illegal_s = 1'b0;
    if (win_n_s < WIDTH'(2)) begin
      cand_n_s = WIDTH'(2);
    end else begin
      cand_n_s = {win_n_s[WIDTH-1:1], 1'b0};
    end
`endif
    if (period_cnt_r == WIDTH'(BURST)) begin
      cnt_inc_s = period_cnt_r;
    end else begin
      cnt_inc_s = period_cnt_r + WIDTH'(1);
    end
    release_s = period_end_s && ((cnt_inc_s == WIDTH'(BURST)) || !Req[owner_r]);
    arb_s     = (state_r == ST_IDLE) || ((state_r == ST_RUN) && release_s);
    take_s    = arb_s && found_s && !illegal_s;
    half_s    = n_latched_r >> 1;
  end

  // Next-state logic.
  always_comb begin
    state_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (take_s) state_s = ST_LOAD;
        else        state_s = ST_IDLE;
      end
      ST_LOAD: state_s = ST_RUN;
      ST_RUN: begin
        if (!release_s)  state_s = ST_RUN;
        else if (take_s) state_s = ST_LOAD;
        else             state_s = ST_IDLE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Output values for the coming cycle, registered below.
  always_comb begin
    if (take_s) begin
      owner_next_s = win_s;
    end else begin
      owner_next_s = owner_r;
    end
    if (state_s != ST_IDLE) begin
      grant_s = {{(NREQ-1){1'b0}}, 1'b1} << owner_next_s;
    end else begin
      grant_s = {NREQ{1'b0}};
    end
    busy_s = (state_s != ST_IDLE);
    err_s  = arb_s && found_s && illegal_s;
  end

  // State register.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state_r <= ST_IDLE;
    else        state_r <= state_s;
  end

  // Ownership, latched period, burst count and registered outputs.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      owner_r      <= {IDXW{1'b0}};
      last_owner_r <= IDXW'(NREQ - 1);
      n_latched_r  <= {WIDTH{1'b0}};
      period_cnt_r <= {WIDTH{1'b0}};
      grant_r      <= {NREQ{1'b0}};
      busy_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      if (take_s) begin
        owner_r      <= win_s;
        last_owner_r <= win_s;
        n_latched_r  <= cand_n_s;
        period_cnt_r <= {WIDTH{1'b0}};
      end else if (err_s) begin
        last_owner_r <= win_s;
      end else if ((state_r == ST_RUN) && period_end_s) begin
        period_cnt_r <= cnt_inc_s;
      end else begin
        period_cnt_r <= period_cnt_r;
      end
      grant_r <= grant_s;
      busy_r  <= busy_s;
      err_r   <= err_s;
    end
  end

  even_period_divider #(.WIDTH(WIDTH)) u_div (
    .Clock      (Clock),
    .Reset      (Reset),
    .load       (take_s),
    .enable     (state_s == ST_RUN),
    .half       (half_s),
    .out        (out_s),
    .period_end (period_end_s)
  );

  assign Grant       = grant_r;
  assign OUT         = out_s;
  assign Busy        = busy_r;
  assign Period_done = period_end_s;
  assign Err         = err_r;

endmodule

// File: tb/tb_clock_share_arbiter.sv
// Scoreboard bench: stimulus queues expected grant/period/idle/err events,
// a monitor pops and checks them as the DUT produces them.
module tb_clock_share_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 16;
  localparam int K_GRANT  = 0;
  localparam int K_PERIOD = 1;
  localparam int K_IDLE   = 2;
  localparam int K_ERR    = 3;

  logic                  Clock = 1'b0;
  logic                  Reset = 1'b0;
  logic [NREQ-1:0]       Req   = 4'b0000;
  logic [NREQ*WIDTH-1:0] DivN  = 64'd0;
  logic [NREQ-1:0]       Grant;
  logic                  OUT, Busy, Period_done, Err;

  typedef struct {
    int kind;
    int grant;
    int n;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  clock_share_arbiter dut (
    .Clock(Clock), .Reset(Reset), .Req(Req), .DivN(DivN),
    .Grant(Grant), .OUT(OUT), .Busy(Busy), .Period_done(Period_done), .Err(Err)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic push(input int k, input int g, input int n);
    ev_t e;
    e.kind = k; e.grant = g; e.n = n;
    exp_q.push_back(e);
  endtask

  task automatic set_n(input int i, input int n);
    DivN[i*WIDTH +: WIDTH] = 16'(n);
  endtask

  task automatic wait_done(input int cnt);
    int seen = 0;
    for (int c = 0; c < 4000 && seen < cnt; c++) begin
      @(negedge Clock);
      if (Period_done) seen++;
    end
    if (seen < cnt) chk("wait_done_timeout", seen, cnt);
  endtask

  task automatic wait_high();
    int got = 0;
    for (int c = 0; c < 200 && got == 0; c++) begin
      @(negedge Clock);
      if (OUT) got = 1;
    end
    if (got == 0) chk("wait_high_timeout", got, 1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic pop_expect(input int kind, output ev_t e, output bit ok);
    ok = 1'b0;
    e.kind = -1; e.grant = 0; e.n = 0;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event actual_kind=%0d expected=none at %0t", kind, $time);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      ok = (kind == e.kind);
    end
  endtask

  // Monitor: measures OUT phases and checks every DUT event against the queue.
  initial begin
    int   hi = 0, lo = 0, since = 0;
    logic prev_out = 1'b0, prev_done = 1'b0;
    logic [NREQ-1:0] prev_grant = 4'b0000;
    ev_t  e;
    bit   ok;
    forever begin
      @(negedge Clock);
      since++;
      if (OUT) begin
        if (!prev_out) begin hi = 1; lo = 0; end
        else hi++;
      end else begin
        if (prev_out) lo = 1;
        else lo++;
      end
      if (Grant == 4'b0000 && prev_grant != 4'b0000) begin
        pop_expect(K_IDLE, e, ok);
        chk("idle_busy", int'(Busy), 0);
      end
      if (Err) pop_expect(K_ERR, e, ok);
      if (Grant != 4'b0000 && (prev_grant == 4'b0000 || (prev_done && !OUT))) begin
        pop_expect(K_GRANT, e, ok);
        if (ok) chk("grant_owner", int'(Grant), e.grant);
        chk("load_out_low", int'(OUT), 0);
        chk("load_busy", int'(Busy), 1);
        since = 0;
      end
      if (Period_done) begin
        pop_expect(K_PERIOD, e, ok);
        if (ok) begin
          chk("period_grant", int'(Grant), e.grant);
          chk("period_len", since, e.n);
          chk("period_high", hi, e.n / 2);
          chk("period_low", lo, e.n / 2);
        end
        since = 0;
      end
      prev_out   = OUT;
      prev_done  = Period_done;
      prev_grant = Grant;
    end
  end

  // Directed scenarios.
  initial begin
    repeat (3) @(negedge Clock);
    chk("rst_grant", int'(Grant), 0);
    chk("rst_out", int'(OUT), 0);
    chk("rst_busy", int'(Busy), 0);
    chk("rst_done", int'(Period_done), 0);
    chk("rst_err", int'(Err), 0);
    #2 Reset = 1'b1;

    // Single requester, N=4: burst of 8, re-grant through LOAD, then release.
    set_n(0, 4);
    push(K_GRANT, 1, 0);
    repeat (8) push(K_PERIOD, 1, 4);
    push(K_GRANT, 1, 0);
    repeat (2) push(K_PERIOD, 1, 4);
    push(K_IDLE, 0, 0);
    @(negedge Clock);
    Req = 4'b0001;
    wait_done(10);
    Req = 4'b0000;
    idle_cycles(4);

    // Two requesters alternate every 8 periods (last owner was 0, so 2 first).
    set_n(2, 6);
    push(K_GRANT, 4, 0);
    repeat (8) push(K_PERIOD, 4, 6);
    push(K_GRANT, 1, 0);
    repeat (8) push(K_PERIOD, 1, 4);
    push(K_GRANT, 4, 0);
    repeat (2) push(K_PERIOD, 4, 6);
    push(K_IDLE, 0, 0);
    Req = 4'b0101;
    wait_done(18);
    Req = 4'b0000;
    idle_cycles(4);

    // Request dropped one cycle into the high phase: full period still emitted.
    set_n(0, 8);
    push(K_GRANT, 1, 0);
    push(K_PERIOD, 1, 8);
    push(K_IDLE, 0, 0);
    Req = 4'b0001;
    wait_high();
    @(negedge Clock);
    Req = 4'b0000;
    wait_done(1);
    idle_cycles(4);

    // DivN change mid-run only takes effect at the next grant.
    set_n(1, 6);
    push(K_GRANT, 2, 0);
    repeat (3) push(K_PERIOD, 2, 6);
    push(K_IDLE, 0, 0);
    push(K_GRANT, 2, 0);
    push(K_PERIOD, 2, 10);
    push(K_IDLE, 0, 0);
    Req = 4'b0010;
    wait_high();
    set_n(1, 10);
    wait_done(3);
    Req = 4'b0000;
    idle_cycles(4);
    Req = 4'b0010;
    wait_done(1);
    Req = 4'b0000;
    idle_cycles(4);

    // Odd period on the round-robin winner (requester 0).
    set_n(0, 5);
    set_n(1, 4);
`ifdef CLKSHARE_ERR_CHECK_EN
    push(K_ERR, 0, 0);
    push(K_GRANT, 2, 0);
    repeat (2) push(K_PERIOD, 2, 4);
`else
    push(K_GRANT, 1, 0);
    repeat (2) push(K_PERIOD, 1, 4);
`endif
    push(K_IDLE, 0, 0);
    Req = 4'b0011;
    wait_done(2);
    Req = 4'b0000;
    idle_cycles(4);

    // Asynchronous reset mid-run, then requester 0 has first priority again.
    set_n(0, 4);
    push(K_GRANT, 1, 0);
    push(K_IDLE, 0, 0);
    push(K_GRANT, 1, 0);
    push(K_PERIOD, 1, 4);
    push(K_IDLE, 0, 0);
    Req = 4'b0001;
    wait_high();
    @(negedge Clock);
    #2 Reset = 1'b0;
    #1;
    chk("async_rst_out", int'(OUT), 0);
    chk("async_rst_grant", int'(Grant), 0);
    chk("async_rst_busy", int'(Busy), 0);
    Req = 4'b0000;
    idle_cycles(2);
    #2 Reset = 1'b1;
    @(negedge Clock);
    Req = 4'b0011;
    wait_done(1);
    Req = 4'b0000;
    idle_cycles(6);

    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
